control_sequencer: RTL and testbench

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

---
 rtl/control_sequencer.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_control_sequencer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// ----------------------------------------------------------------------------
// control_sequencer
//   Hard-wired Moore control unit for the CPU datapath. It steps through
//   fetch (T0..T2) and the execute states (T3..T7). The execute path depends
//   on the opcode held in IR. Every control strobe is decoded from the
//   current state and the opcode, so clr and stop only influence the next
//   state.
//
// Ports
//   clk        rising-edge system clock
//   clr        synchronous active-low reset
//   opcode     IR[31:27], valid from T3 onward
//   stop       level request to halt at the next instruction boundary
//   PCout .. RAMrd   datapath / memory / port control strobes
//   alu_op     ALU operation, non-zero only while ZIn is high
//   run        high while sequencing, low in HALT
//   state      current state code (debug)
// ----------------------------------------------------------------------------
module control_sequencer (
    input  logic       clk,
    input  logic       clr,
    input  logic [4:0] opcode,
    input  logic       stop,
    output logic       PCout,
    output logic       MARin,
    output logic       IncPC,
    output logic       Read,
    output logic       MDRin,
    output logic       MDRout,
    output logic       IRin,
    output logic       Yin,
    output logic       ZIn,
    output logic       Zlowout,
    output logic       Zhighout,
    output logic       Cout,
    output logic       Baout,
    output logic       Gra,
    output logic       Grb,
    output logic       Grc,
    output logic       Rin,
    output logic       Rout,
    output logic       HIout,
    output logic       LOout,
    output logic       InPortout,
    output logic       OutPortin,
    output logic       RAMin,
    output logic       RAMrd,
    output logic [4:0] alu_op,
    output logic       run,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_RESET = 4'b0000,
        S_T0    = 4'b0111,
        S_T1    = 4'b1000,
        S_T2    = 4'b1001,
        S_T3    = 4'b1010,
        S_T4    = 4'b1011,
        S_T5    = 4'b1100,
        S_T6    = 4'b1101,
        S_T7    = 4'b1110,
        S_HALT  = 4'b1111
    } state_t;

    typedef enum logic [3:0] {
        K_NOP,
        K_ALU,
        K_ADDI,
        K_LD,
        K_ST,
        K_OUT,
        K_IN,
        K_MFHI,
        K_MFLO,
        K_HALT
    } kind_t;

    localparam logic [4:0] ALU_ADD = 5'b00011;

    state_t state_q;
    state_t state_d;
    kind_t  kind;

    // Instruction class; anything not recognised behaves as nop.
    always_comb begin
        kind = K_NOP;
        case (opcode)
            5'b00000: kind = K_LD;
            5'b00010: kind = K_ST;
            5'b00011,
            5'b00100,
            5'b00101,
            5'b00110: kind = K_ALU;
            5'b01100: kind = K_ADDI;
            5'b10110: kind = K_OUT;
            5'b10111: kind = K_IN;
            5'b11000: kind = K_MFHI;
            5'b11001: kind = K_MFLO;
            5'b11011: kind = K_HALT;
            default:  kind = K_NOP;
        endcase
    end

    // Next state. stop is looked at only in the final execute state of the
    // instruction in flight.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RESET: state_d = S_T0;
            S_T0:    state_d = S_T1;
            S_T1:    state_d = S_T2;
            S_T2:    state_d = S_T3;
            S_T3: begin
                case (kind)
                    K_ALU, K_ADDI, K_LD, K_ST: state_d = S_T4;
                    K_HALT:                    state_d = S_HALT;
                    default:                   state_d = stop ? S_HALT : S_T0;
                endcase
            end
            S_T4:    state_d = S_T5;
            S_T5: begin
                if (kind == K_LD || kind == K_ST) begin
                    state_d = S_T6;
                end else begin
                    state_d = stop ? S_HALT : S_T0;
                end
            end
            S_T6:    state_d = S_T7;
            S_T7:    state_d = stop ? S_HALT : S_T0;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_RESET;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            state_q <= S_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    // Control decode from state register and opcode.
    always_comb begin
        PCout     = 1'b0;
        MARin     = 1'b0;
        IncPC     = 1'b0;
        Read      = 1'b0;
        MDRin     = 1'b0;
        MDRout    = 1'b0;
        IRin      = 1'b0;
        Yin       = 1'b0;
        ZIn       = 1'b0;
        Zlowout   = 1'b0;
        Zhighout  = 1'b0;
        Cout      = 1'b0;
        Baout     = 1'b0;
        Gra       = 1'b0;
        Grb       = 1'b0;
        Grc       = 1'b0;
        Rin       = 1'b0;
        Rout      = 1'b0;
        HIout     = 1'b0;
        LOout     = 1'b0;
        InPortout = 1'b0;
        OutPortin = 1'b0;
        RAMin     = 1'b0;
        RAMrd     = 1'b0;
        alu_op    = '0;
        run       = (state_q != S_HALT);

        case (state_q)
            S_T0: begin
                PCout = 1'b1;
                MARin = 1'b1;
                IncPC = 1'b1;
                RAMrd = 1'b1;
            end
            S_T1: begin
                Read  = 1'b1;
                MDRin = 1'b1;
                RAMrd = 1'b1;
            end
            S_T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            S_T3: begin
                case (kind)
                    K_ALU, K_ADDI: begin
                        Grb  = 1'b1;
                        Rout = 1'b1;
                        Yin  = 1'b1;
                    end
                    K_LD, K_ST: begin
                        Grb   = 1'b1;
                        Baout = 1'b1;
                        Yin   = 1'b1;
                    end
                    K_OUT: begin
                        Gra       = 1'b1;
                        Rout      = 1'b1;
                        OutPortin = 1'b1;
                    end
                    K_IN: begin
                        InPortout = 1'b1;
                        Gra       = 1'b1;
                        Rin       = 1'b1;
                    end
                    K_MFHI: begin
                        HIout = 1'b1;
                        Gra   = 1'b1;
                        Rin   = 1'b1;
                    end
                    K_MFLO: begin
                        LOout = 1'b1;
                        Gra   = 1'b1;
                        Rin   = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T4: begin
                case (kind)
                    K_ALU: begin
                        Grc    = 1'b1;
                        Rout   = 1'b1;
                        ZIn    = 1'b1;
                        alu_op = opcode;
                    end
                    K_ADDI, K_LD, K_ST: begin
                        Cout   = 1'b1;
                        ZIn    = 1'b1;
                        alu_op = ALU_ADD;
                    end
                    default: ;
                endcase
            end
            S_T5: begin
                case (kind)
                    K_ALU, K_ADDI: begin
                        Zlowout = 1'b1;
                        Gra     = 1'b1;
                        Rin     = 1'b1;
                    end
                    K_LD, K_ST: begin
                        Zlowout = 1'b1;
                        MARin   = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T6: begin
                case (kind)
                    K_LD: begin
                        Read  = 1'b1;
                        MDRin = 1'b1;
                        RAMrd = 1'b1;
                    end
                    K_ST: begin
                        Gra   = 1'b1;
                        Rout  = 1'b1;
                        MDRin = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T7: begin
                case (kind)
                    K_LD: begin
                        MDRout = 1'b1;
                        Gra    = 1'b1;
                        Rin    = 1'b1;
                    end
                    K_ST: begin
                        RAMin = 1'b1;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    assign state = state_q;

endmodule

// File: tb/tb_control_sequencer.sv
// ----------------------------------------------------------------------------
// tb_control_sequencer
//   Cycle-by-cycle check of control_sequencer. Each record gives the inputs
//   for one clock cycle together with the state, control strobes, alu_op and
//   run expected during that cycle. Records are pushed on a scoreboard queue
//   as they are driven and popped when the outputs are sampled, mid low phase.
// ----------------------------------------------------------------------------
module tb_control_sequencer;

    logic       clk;
    logic       clr;
    logic [4:0] opcode;
    logic       stop;
    logic       PCout, MARin, IncPC, Read, MDRin, MDRout, IRin;
    logic       Yin, ZIn, Zlowout, Zhighout, Cout, Baout;
    logic       Gra, Grb, Grc, Rin, Rout;
    logic       HIout, LOout, InPortout, OutPortin, RAMin, RAMrd;
    logic [4:0] alu_op;
    logic       run;
    logic [3:0] state;

    control_sequencer dut (
        .clk       (clk),
        .clr       (clr),
        .opcode    (opcode),
        .stop      (stop),
        .PCout     (PCout),
        .MARin     (MARin),
        .IncPC     (IncPC),
        .Read      (Read),
        .MDRin     (MDRin),
        .MDRout    (MDRout),
        .IRin      (IRin),
        .Yin       (Yin),
        .ZIn       (ZIn),
        .Zlowout   (Zlowout),
        .Zhighout  (Zhighout),
        .Cout      (Cout),
        .Baout     (Baout),
        .Gra       (Gra),
        .Grb       (Grb),
        .Grc       (Grc),
        .Rin       (Rin),
        .Rout      (Rout),
        .HIout     (HIout),
        .LOout     (LOout),
        .InPortout (InPortout),
        .OutPortin (OutPortin),
        .RAMin     (RAMin),
        .RAMrd     (RAMrd),
        .alu_op    (alu_op),
        .run       (run),
        .state     (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control strobes packed one bit each.
    localparam logic [23:0] PCOUT = 24'h000001, MARIN = 24'h000002, INCPC = 24'h000004,
                            READ  = 24'h000008, MDRIN = 24'h000010, MDROUT = 24'h000020,
                            IRIN  = 24'h000040, YIN   = 24'h000080, ZIN    = 24'h000100,
                            ZLOW  = 24'h000200, ZHIGH = 24'h000400, COUT   = 24'h000800,
                            BAOUT = 24'h001000, GRA   = 24'h002000, GRB    = 24'h004000,
                            GRC   = 24'h008000, RIN   = 24'h010000, ROUT   = 24'h020000,
                            HIOUT = 24'h040000, LOOUT = 24'h080000, INPORT = 24'h100000,
                            OUTPORT = 24'h200000, RAMIN = 24'h400000, RAMRD = 24'h800000;
    localparam logic [23:0] NONE = 24'h000000;

    localparam logic [3:0] ST_RESET = 4'h0, ST_T0 = 4'h7, ST_T1 = 4'h8, ST_T2 = 4'h9,
                           ST_T3 = 4'hA, ST_T4 = 4'hB, ST_T5 = 4'hC, ST_T6 = 4'hD,
                           ST_T7 = 4'hE, ST_HALT = 4'hF;

    localparam logic [4:0] OP_LD = 5'b00000, OP_ST = 5'b00010, OP_ADD = 5'b00011,
                           OP_SUB = 5'b00100, OP_AND = 5'b00101, OP_OR = 5'b00110,
                           OP_ADDI = 5'b01100, OP_OUT = 5'b10110, OP_IN = 5'b10111,
                           OP_MFHI = 5'b11000, OP_MFLO = 5'b11001, OP_NOP = 5'b11010,
                           OP_HALT = 5'b11011, OP_UND1 = 5'b11111, OP_UND2 = 5'b00001;

    typedef struct {
        logic        clr;
        logic [4:0]  op;
        logic        stp;
        logic [3:0]  st;
        logic [23:0] ctrl;
        logic [4:0]  alu;
        logic        run;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   row_id = 0;

    logic [23:0] ctrl_act;
    assign ctrl_act = {RAMrd, RAMin, OutPortin, InPortout, LOout, HIout, Rout, Rin,
                       Grc, Grb, Gra, Baout, Cout, Zhighout, Zlowout, ZIn,
                       Yin, IRin, MDRout, MDRin, Read, IncPC, MARin, PCout};

    function automatic vec_t row(input logic c, input logic [4:0] op, input logic s,
                                 input logic [3:0] st, input logic [23:0] ctrl,
                                 input logic [4:0] alu, input logic r);
        vec_t v;
        v.clr = c; v.op = op; v.stp = s; v.st = st; v.ctrl = ctrl; v.alu = alu; v.run = r;
        return v;
    endfunction

    // Table-fill helper: fetch cycles of one instruction.
    task automatic t_fetch(input logic [4:0] op, input logic s);
        tbl.push_back(row(1'b1, op, s, ST_T0, PCOUT | MARIN | INCPC | RAMRD, 5'b0, 1'b1));
        tbl.push_back(row(1'b1, op, s, ST_T1, READ | MDRIN | RAMRD, 5'b0, 1'b1));
        tbl.push_back(row(1'b1, op, s, ST_T2, MDROUT | IRIN, 5'b0, 1'b1));
    endtask

    task automatic t_alu(input logic [4:0] op, input logic [4:0] alu_exp, input logic s);
        t_fetch(op, s);
        tbl.push_back(row(1'b1, op, s, ST_T3, GRB | ROUT | YIN, 5'b0, 1'b1));
        tbl.push_back(row(1'b1, op, s, ST_T4, GRC | ROUT | ZIN, alu_exp, 1'b1));
        tbl.push_back(row(1'b1, op, 1'b0, ST_T5, ZLOW | GRA | RIN, 5'b0, 1'b1));
    endtask

    task automatic t_single(input logic [4:0] op, input logic [23:0] t3);
        t_fetch(op, 1'b0);
        tbl.push_back(row(1'b1, op, 1'b0, ST_T3, t3, 5'b0, 1'b1));
    endtask

    // Drive one cycle, queue its expectation, then sample and compare.
    task automatic apply(input vec_t v);
        vec_t e;
        @(negedge clk);
        clr    = v.clr;
        opcode = v.op;
        stop   = v.stp;
        exp_q.push_back(v);
        #2;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL row%0d scoreboard: queue empty, required one entry", row_id);
        end else begin
            e = exp_q.pop_front();
            if ({state, ctrl_act, alu_op, run} !== {e.st, e.ctrl, e.alu, e.run}) begin
                n_bad++;
                $display("FAIL row%0d op=%b: got state=%h ctrl=%h alu=%b run=%b, required state=%h ctrl=%h alu=%b run=%b",
                         row_id, v.op, state, ctrl_act, alu_op, run, e.st, e.ctrl, e.alu, e.run);
            end
        end
        row_id++;
    endtask

    task automatic h_fetch(input logic [4:0] op);
        apply(row(1'b1, op, 1'b0, ST_T0, PCOUT | MARIN | INCPC | RAMRD, 5'b0, 1'b1));
        apply(row(1'b1, op, 1'b0, ST_T1, READ | MDRIN | RAMRD, 5'b0, 1'b1));
        apply(row(1'b1, op, 1'b0, ST_T2, MDROUT | IRIN, 5'b0, 1'b1));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clr    = 1'b0;
        opcode = '0;
        stop   = 1'b0;

        // Reset held, released, then out / add / sub / addi / ld / undefined ...
        tbl.push_back(row(1'b0, OP_OUT, 1'b0, ST_RESET, NONE, 5'b0, 1'b1));
        tbl.push_back(row(1'b0, OP_OUT, 1'b1, ST_RESET, NONE, 5'b0, 1'b1));
        tbl.push_back(row(1'b1, OP_OUT, 1'b0, ST_RESET, NONE, 5'b0, 1'b1));
        t_single(OP_OUT, GRA | ROUT | OUTPORT);
        t_alu(OP_ADD, 5'b00011, 1'b0);
        t_alu(OP_SUB, 5'b00100, 1'b0);
        t_fetch(OP_ADDI, 1'b0);
        tbl.push_back(row(1'b1, OP_ADDI, 1'b0, ST_T3, GRB | ROUT | YIN, 5'b0, 1'b1));
        tbl.push_back(row(1'b1, OP_ADDI, 1'b0, ST_T4, COUT | ZIN, 5'b00011, 1'b1));
        tbl.push_back(row(1'b1, OP_ADDI, 1'b0, ST_T5, ZLOW | GRA | RIN, 5'b0, 1'b1));
        t_fetch(OP_LD, 1'b0);
        tbl.push_back(row(1'b1, OP_LD, 1'b0, ST_T3, GRB | BAOUT | YIN, 5'b0, 1'b1));
        tbl.push_back(row(1'b1, OP_LD, 1'b0, ST_T4, COUT | ZIN, 5'b00011, 1'b1));
        tbl.push_back(row(1'b1, OP_LD, 1'b0, ST_T5, ZLOW | MARIN, 5'b0, 1'b1));
        tbl.push_back(row(1'b1, OP_LD, 1'b0, ST_T6, READ | MDRIN | RAMRD, 5'b0, 1'b1));
        tbl.push_back(row(1'b1, OP_LD, 1'b0, ST_T7, MDROUT | GRA | RIN, 5'b0, 1'b1));
        t_single(OP_UND1, NONE);
        t_single(OP_UND2, NONE);
        t_single(OP_IN, INPORT | GRA | RIN);
        t_single(OP_MFHI, HIOUT | GRA | RIN);
        t_single(OP_MFLO, LOOUT | GRA | RIN);
        t_single(OP_NOP, NONE);
        // stop high outside the final execute cycle must be ignored
        t_alu(OP_AND, 5'b00101, 1'b1);
        t_alu(OP_OR, 5'b00110, 1'b0);
        t_fetch(OP_LD, 1'b1);
        tbl.push_back(row(1'b1, OP_LD, 1'b1, ST_T3, GRB | BAOUT | YIN, 5'b0, 1'b1));
        tbl.push_back(row(1'b1, OP_LD, 1'b1, ST_T4, COUT | ZIN, 5'b00011, 1'b1));
        tbl.push_back(row(1'b1, OP_LD, 1'b1, ST_T5, ZLOW | MARIN, 5'b0, 1'b1));
        tbl.push_back(row(1'b1, OP_LD, 1'b1, ST_T6, READ | MDRIN | RAMRD, 5'b0, 1'b1));
        tbl.push_back(row(1'b1, OP_LD, 1'b0, ST_T7, MDROUT | GRA | RIN, 5'b0, 1'b1));

        repeat (2) @(posedge clk);
        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i]);
        end

        // st with stop in T7 -> HALT, HALT holds until clr
        h_fetch(OP_ST);
        apply(row(1'b1, OP_ST, 1'b0, ST_T3, GRB | BAOUT | YIN, 5'b0, 1'b1));
        apply(row(1'b1, OP_ST, 1'b0, ST_T4, COUT | ZIN, 5'b00011, 1'b1));
        apply(row(1'b1, OP_ST, 1'b0, ST_T5, ZLOW | MARIN, 5'b0, 1'b1));
        apply(row(1'b1, OP_ST, 1'b0, ST_T6, GRA | ROUT | MDRIN, 5'b0, 1'b1));
        apply(row(1'b1, OP_ST, 1'b1, ST_T7, RAMIN, 5'b0, 1'b1));
        apply(row(1'b1, OP_ST, 1'b0, ST_HALT, NONE, 5'b0, 1'b0));
        apply(row(1'b1, OP_ADD, 1'b1, ST_HALT, NONE, 5'b0, 1'b0));
        apply(row(1'b0, OP_ADD, 1'b0, ST_HALT, NONE, 5'b0, 1'b0));
        apply(row(1'b1, OP_ADD, 1'b0, ST_RESET, NONE, 5'b0, 1'b1));

        // clr during T4 of add abandons the instruction before T5
        h_fetch(OP_ADD);
        apply(row(1'b1, OP_ADD, 1'b0, ST_T3, GRB | ROUT | YIN, 5'b0, 1'b1));
        apply(row(1'b0, OP_ADD, 1'b0, ST_T4, GRC | ROUT | ZIN, 5'b00011, 1'b1));
        apply(row(1'b1, OP_ADD, 1'b0, ST_RESET, NONE, 5'b0, 1'b1));

        // halt instruction goes to HALT with stop low
        h_fetch(OP_HALT);
        apply(row(1'b1, OP_HALT, 1'b0, ST_T3, NONE, 5'b0, 1'b1));
        apply(row(1'b1, OP_HALT, 1'b0, ST_HALT, NONE, 5'b0, 1'b0));
        apply(row(1'b0, OP_HALT, 1'b0, ST_HALT, NONE, 5'b0, 1'b0));
        apply(row(1'b1, OP_OUT, 1'b0, ST_RESET, NONE, 5'b0, 1'b1));

        // single-cycle out with stop at T3 halts after it
        h_fetch(OP_OUT);
        apply(row(1'b1, OP_OUT, 1'b1, ST_T3, GRA | ROUT | OUTPORT, 5'b0, 1'b1));
        apply(row(1'b0, OP_OUT, 1'b0, ST_HALT, NONE, 5'b0, 1'b0));
        apply(row(1'b1, OP_NOP, 1'b0, ST_RESET, NONE, 5'b0, 1'b1));
        apply(row(1'b1, OP_NOP, 1'b0, ST_T0, PCOUT | MARIN | INCPC | RAMRD, 5'b0, 1'b1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
